// File: rtl/regfile_write_arbiter_pkg.sv
// rtl/regfile_write_arbiter_pkg.sv - shared pipeline register-file constants and writeback request type
package regfile_write_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int XLEN       = 32;

  localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/wb_result_fifo.sv
// rtl/wb_result_fifo.sv - small synchronous FIFO buffering long-latency results (addr + data)
module wb_result_fifo
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 2,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [REG_ADDR_W-1:0] push_addr,
  input  logic [DW-1:0]         push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [PW:0]           count,
  output logic [REG_ADDR_W-1:0] head_addr,
  output logic [DW-1:0]         head_data
);

  logic [REG_ADDR_W-1:0] addr_mem [DEPTH];
  logic [DW-1:0]         data_mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

  assign full      = (count == (PW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - register-file write-port arbiter with long-latency scoreboard
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wb_valid,
  input  logic [4:0]                    wb_addr,
  input  logic [XLEN-1:0]               wb_data,
  input  logic                          issue_valid,
  input  logic [4:0]                    issue_addr,
  output logic                          issue_ready,
  input  logic                          mc_valid,
  output logic                          mc_ready,
  input  logic [4:0]                    mc_addr,
  input  logic [XLEN-1:0]               mc_data,
  input  logic [4:0]                    rs1_addr,
  input  logic [4:0]                    rs2_addr,
  output logic                          hazard_stall,
  output logic                          pipe_stall,
  output logic                          rf_reg_write,
  output logic [4:0]                    rf_addrD,
  output logic [XLEN-1:0]               rf_dataD,
  output logic [31:0]                   busy_vec,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busy_next;
  logic [3:0]            starve_cnt;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  wb_grant;
  logic                  head_grant;
  logic                  issue_accept;
  logic [REG_ADDR_W-1:0] head_addr;
  logic [XLEN-1:0]       head_data;

  wb_result_fifo #(
    .DW    (XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_addr (mc_addr),
    .push_data (mc_data),
    .pop       (head_grant),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head_addr (head_addr),
    .head_data (head_data)
  );

  // The pipeline cannot be back-pressured, so it always wins the port
  assign wb_grant     = reset && wb_valid && (wb_addr != REG_X0);
  assign head_grant   = reset && !wb_grant && !fifo_empty;
  assign mc_ready     = reset && !fifo_full;
  assign push         = mc_valid && mc_ready && (mc_addr != REG_X0);
  assign issue_ready  = reset && ((issue_addr == REG_X0) || !busy[issue_addr]);
  assign issue_accept = issue_valid && issue_ready && (issue_addr != REG_X0);

  always_comb begin
    rf_reg_write = 1'b0;
    rf_addrD     = REG_X0;
    rf_dataD     = '0;
    if (wb_grant) begin
      rf_reg_write = 1'b1;
      rf_addrD     = wb_addr;
      rf_dataD     = wb_data;
    end else if (head_grant) begin
      rf_reg_write = 1'b1;
      rf_addrD     = head_addr;
      rf_dataD     = head_data;
    end
  end

  // Set is applied after clear so it wins on a shared register
  always_comb begin
    busy_next = busy;
    if (head_grant) busy_next[head_addr] = 1'b0;
    if (issue_accept) busy_next[issue_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (fifo_empty || head_grant) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign pipe_stall   = (starve_cnt == STARVE_MAX);
  assign hazard_stall = reset && (((rs1_addr != REG_X0) && busy[rs1_addr]) ||
                                  ((rs2_addr != REG_X0) && busy[rs2_addr]));
  assign busy_vec     = busy;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - scoreboard bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  localparam int XLEN         = 32;
  localparam int FIFO_DEPTH   = 2;
  localparam int STARVE_LIMIT = 4;

  logic              clk;
  logic              reset;
  logic              wb_valid;
  logic [4:0]        wb_addr;
  logic [XLEN-1:0]   wb_data;
  logic              issue_valid;
  logic [4:0]        issue_addr;
  logic              issue_ready;
  logic              mc_valid;
  logic              mc_ready;
  logic [4:0]        mc_addr;
  logic [XLEN-1:0]   mc_data;
  logic [4:0]        rs1_addr;
  logic [4:0]        rs2_addr;
  logic              hazard_stall;
  logic              pipe_stall;
  logic              rf_reg_write;
  logic [4:0]        rf_addrD;
  logic [XLEN-1:0]   rf_dataD;
  logic [31:0]       busy_vec;
  logic [1:0]        fifo_count;

  regfile_write_arbiter #(
    .XLEN         (XLEN),
    .FIFO_DEPTH   (FIFO_DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wb_valid     (wb_valid),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .issue_valid  (issue_valid),
    .issue_addr   (issue_addr),
    .issue_ready  (issue_ready),
    .mc_valid     (mc_valid),
    .mc_ready     (mc_ready),
    .mc_addr      (mc_addr),
    .mc_data      (mc_data),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .hazard_stall (hazard_stall),
    .pipe_stall   (pipe_stall),
    .rf_reg_write (rf_reg_write),
    .rf_addrD     (rf_addrD),
    .rf_dataD     (rf_dataD),
    .busy_vec     (busy_vec),
    .fifo_count   (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mbusy = '0;
  int          mstarve = 0;

  // Reference model: expected results are queued when the bench offers them and popped on the write they should produce
  always @(negedge clk) begin : monitor
    bit wbg;
    bit hg;
    bit acc;
    int sz;
    if (!reset) begin
      check("rst_we", rf_reg_write, 0);
      check("rst_addr", rf_addrD, 0);
      check("rst_data", rf_dataD, 0);
      check("rst_mc_ready", mc_ready, 0);
      check("rst_issue_ready", issue_ready, 0);
      check("rst_hazard", hazard_stall, 0);
      check("rst_pipe_stall", pipe_stall, 0);
      check("rst_count", fifo_count, 0);
      check("rst_busy", busy_vec, 0);
      q.delete();
      mbusy   = '0;
      mstarve = 0;
    end else begin
      sz  = q.size();
      wbg = wb_valid && (wb_addr != 0);
      hg  = !wbg && (sz > 0);
      check("we", rf_reg_write, wbg || hg);
      if (wbg) begin
        check("wb_addr", rf_addrD, wb_addr);
        check("wb_data", rf_dataD, wb_data);
      end else if (hg) begin
        check("mc_addr", rf_addrD, q[0].addr);
        check("mc_data", rf_dataD, q[0].data);
      end
      check("mc_ready", mc_ready, sz < FIFO_DEPTH);
      acc = (issue_addr == 0) || !mbusy[issue_addr];
      check("issue_ready", issue_ready, acc);
      check("hazard", hazard_stall,
            ((rs1_addr != 0) && mbusy[rs1_addr]) || ((rs2_addr != 0) && mbusy[rs2_addr]));
      check("pipe_stall", pipe_stall, mstarve == STARVE_LIMIT);
      check("count", fifo_count, sz);
      check("busy", busy_vec, mbusy);
      if (hg) begin
        mbusy[q[0].addr] = 1'b0;
        void'(q.pop_front());
      end
      if (issue_valid && acc && (issue_addr != 0)) mbusy[issue_addr] = 1'b1;
      if (sz == 0 || hg) mstarve = 0;
      else if (mstarve < STARVE_LIMIT) mstarve++;
      if (mc_valid && (sz < FIFO_DEPTH) && (mc_addr != 0)) q.push_back('{mc_addr, mc_data});
    end
  end

  task automatic idle();
    wb_valid    = 1'b0;
    wb_addr     = '0;
    wb_data     = '0;
    issue_valid = 1'b0;
    issue_addr  = '0;
    mc_valid    = 1'b0;
    mc_addr     = '0;
    mc_data     = '0;
    rs1_addr    = '0;
    rs2_addr    = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] a);
    issue_valid = 1'b1;
    issue_addr  = a;
    cyc();
    issue_valid = 1'b0;
    issue_addr  = '0;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    repeat (2) cyc();
    mid();
    check("reset_count", fifo_count, 0);
    check("reset_busy", busy_vec, 0);
    cyc();
    reset = 1'b1;
    cyc();

    // priority: pipeline write beats a pending FIFO head
    issue(5'd9);
    mc_valid = 1'b1; mc_addr = 5'd9; mc_data = 32'h22;
    cyc();
    idle();
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h11;
    mid();
    check("prio_wb_addr", rf_addrD, 3);
    check("prio_wb_data", rf_dataD, 32'h11);
    cyc();
    idle();
    mid();
    check("prio_mc_addr", rf_addrD, 9);
    check("prio_mc_data", rf_dataD, 32'h22);
    check("prio_busy9_held", busy_vec[9], 1);
    cyc();
    mid();
    check("prio_busy9_clr", busy_vec[9], 0);
    cyc();

    // scoreboard hazard on x4
    issue(5'd4);
    rs1_addr = 5'd4; issue_valid = 1'b1; issue_addr = 5'd4;
    mid();
    check("haz_set", hazard_stall, 1);
    check("haz_reissue", issue_ready, 0);
    cyc();
    issue_valid = 1'b0; issue_addr = '0;
    repeat (2) cyc();
    mc_valid = 1'b1; mc_addr = 5'd4; mc_data = 32'h44;
    mid();
    check("haz_push_cycle", hazard_stall, 1);
    cyc();
    mc_valid = 1'b0;
    mid();
    check("haz_grant_cycle", hazard_stall, 1);
    check("haz_write_addr", rf_addrD, 4);
    cyc();
    mid();
    check("haz_clear", hazard_stall, 0);
    cyc();
    idle();

    // full boundary with pipeline writes held high
    for (int i = 0; i < 3; i++) issue(5'(10 + i));
    wb_valid = 1'b1; wb_addr = 5'd1; wb_data = 32'hA0;
    mc_valid = 1'b1; mc_addr = 5'd10; mc_data = 32'h100;
    mid();
    check("full_ready_first", mc_ready, 1);
    cyc();
    mc_addr = 5'd11; mc_data = 32'h101;
    cyc();
    mc_addr = 5'd12; mc_data = 32'h102;
    mid();
    check("full_ready_low", mc_ready, 0);
    check("full_count", fifo_count, 2);
    cyc();
    cyc();
    wb_valid = 1'b0;
    mid();
    check("full_pop_ready", mc_ready, 0);
    check("full_pop_addr", rf_addrD, 10);
    cyc();
    mid();
    check("full_third_ready", mc_ready, 1);
    cyc();
    idle();
    repeat (2) cyc();
    mc_valid = 1'b1; mc_addr = 5'd0; mc_data = 32'hDEAD;
    mid();
    check("x0_ready", mc_ready, 1);
    check("x0_we", rf_reg_write, 0);
    cyc();
    idle();
    mid();
    check("x0_count", fifo_count, 0);
    check("x0_we_next", rf_reg_write, 0);
    cyc();

    // starvation: head denied for STARVE_LIMIT cycles
    issue(5'd13);
    wb_valid = 1'b1; wb_addr = 5'd2; wb_data = 32'hB0;
    mc_valid = 1'b1; mc_addr = 5'd13; mc_data = 32'h130;
    cyc();
    mc_valid = 1'b0; mc_addr = '0; mc_data = '0;
    for (int i = 0; i < STARVE_LIMIT; i++) begin
      mid();
      check("starve_pre", pipe_stall, 0);
      cyc();
    end
    mid();
    check("starve_hit", pipe_stall, 1);
    cyc();
    wb_valid = 1'b0;
    mid();
    check("starve_bubble_addr", rf_addrD, 13);
    check("starve_bubble_stall", pipe_stall, 1);
    cyc();
    mid();
    check("starve_release", pipe_stall, 0);
    cyc();
    idle();

    // x0 pipeline write lets the FIFO head through
    issue(5'd14);
    mc_valid = 1'b1; mc_addr = 5'd14; mc_data = 32'h140;
    cyc();
    idle();
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF;
    mid();
    check("x0wb_we", rf_reg_write, 1);
    check("x0wb_addr", rf_addrD, 14);
    check("x0wb_data", rf_dataD, 32'h140);
    cyc();
    idle();
    cyc();

    // asynchronous reset while two results are buffered
    issue(5'd5);
    issue(5'd7);
    rs1_addr = 5'd5;
    wb_valid = 1'b1; wb_addr = 5'd6; wb_data = 32'h60;
    mc_valid = 1'b1; mc_addr = 5'd5; mc_data = 32'h50;
    cyc();
    mc_addr = 5'd7; mc_data = 32'h70;
    cyc();
    mc_valid = 1'b0; mc_addr = '0; mc_data = '0;
    mid();
    check("pre_rst_count", fifo_count, 2);
    check("pre_rst_busy", busy_vec, 32'h0000_00A0);
    check("pre_rst_hazard", hazard_stall, 1);
    #1 reset = 1'b0;
    #1;
    check("arst_count", fifo_count, 0);
    check("arst_busy", busy_vec, 0);
    check("arst_we", rf_reg_write, 0);
    check("arst_addr", rf_addrD, 0);
    check("arst_data", rf_dataD, 0);
    check("arst_hazard", hazard_stall, 0);
    check("arst_pipe_stall", pipe_stall, 0);
    check("arst_mc_ready", mc_ready, 0);
    check("arst_issue_ready", issue_ready, 0);
    idle();
    repeat (2) cyc();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mid();
      check("post_rst_we", rf_reg_write, 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
